// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch FSM states and architectural constants
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD, FULL} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with load and increment enables; load has priority
module fetch_pc_reg #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_addr,
  input  logic                inc,
  output logic [PC_WIDTH-1:0] pc
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= RESET_PC;
    else if (load) pc <= load_addr;
    else if (inc) pc <= pc + PC_WIDTH'(PC_STEP);
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch over a req/ack memory port with a one-entry output buffer
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(cpu_pkg::RESET_PC),
  parameter int PC_STEP = cpu_pkg::PC_STEP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   out_valid,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [INSTR_WIDTH-1:0] out_instruction
);
  import cpu_pkg::*;
  fetch_state_t state, state_nxt;
  logic [PC_WIDTH-1:0] pc, tgt, load_addr;
  logic pc_load, tgt_load, cap, flush;
  fetch_pc_reg #(.PC_WIDTH(PC_WIDTH), .RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk(clk), .rst(rst), .load(pc_load), .load_addr(load_addr), .inc(cap), .pc(pc)
  );
  assign imem_req = state == FETCH || state == DISCARD;
  assign imem_addr = pc;
  // a branch arriving with the discard ack is newer than the stored target
  assign load_addr = (state == DISCARD && !branch_taken) ? tgt : branch_addr;
  always_comb begin
    state_nxt = state;
    pc_load = 1'b0;
    tgt_load = 1'b0;
    cap = 1'b0;
    flush = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        cap = imem_ack && !branch_taken;
        pc_load = imem_ack && branch_taken;
        tgt_load = !imem_ack && branch_taken;
        state_nxt = imem_ack ? (branch_taken ? FETCH : FULL) : (branch_taken ? DISCARD : FETCH);
      end
      DISCARD: begin
        pc_load = imem_ack;
        tgt_load = !imem_ack && branch_taken;
        state_nxt = imem_ack ? FETCH : DISCARD;
      end
      FULL: begin
        pc_load = branch_taken;
        flush = branch_taken || !freeze;
        state_nxt = flush ? FETCH : FULL;
      end
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      tgt <= '0;
      out_valid <= 1'b0;
      out_pc <= '0;
      out_instruction <= INSTR_WIDTH'(NOP_INSTR);
    end else begin
      state <= state_nxt;
      if (tgt_load) tgt <= branch_addr;
      if (cap) begin
        out_valid <= 1'b1;
        out_pc <= pc + PC_WIDTH'(PC_STEP);
        out_instruction <= imem_rdata;
      end else if (flush) begin
        out_valid <= 1'b0;
        out_pc <= '0;
        out_instruction <= INSTR_WIDTH'(NOP_INSTR);
      end
    end
  end
endmodule
